// File: rtl/dm_store_buffer_pkg.sv
// Shared types and constants for the data-memory posted-write store buffer.
package dm_store_buffer_pkg;

  localparam int SB_DEPTH = 4;

  typedef struct packed {
    logic [29:0] tag;
    logic [3:0]  mask;
    logic [31:0] data;
  } sb_entry_t;

  // SRAM port command for the current cycle; a read is signalled by an all-zero write mask
  typedef enum logic [1:0] {
    SB_CMD_IDLE,
    SB_CMD_READ,
    SB_CMD_DRAIN
  } sb_cmd_e;

  localparam logic [3:0] SB_WEN_READ = 4'b0000;

endpackage

// File: rtl/dm_store_buffer_fwd_merge.sv
// Youngest-match byte select over the store-buffer entries for load forwarding.
module sb_fwd_merge
  import dm_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  sb_entry_t                   ents [DEPTH],
  input  logic [DEPTH-1:0]            vld,
  input  logic [$clog2(DEPTH)-1:0]    head,
  input  logic [29:0]                 tag,
  output logic [3:0]                  fwd_mask,
  output logic [31:0]                 fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so later matches overwrite earlier ones per lane
  always_comb begin
    fwd_mask = '0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (vld[idx] && (ents[idx].tag == tag)) begin
        for (int b = 0; b < 4; b++) begin
          if (ents[idx].mask[b]) begin
            fwd_mask[b]         = 1'b1;
            fwd_data[8*b +: 8]  = ents[idx].data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write store buffer between the M stage and the single-port data SRAM,
// with in-order drain, load priority and byte-merged load forwarding.
module dm_store_buffer
  import dm_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  st_en,
  input  logic        ld_req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        stall,
  output logic        empty,
  output logic [31:0] sram_addr,
  output logic [3:0]  sram_w_en,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  sb_entry_t        ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_n;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q, count_n;
  logic [31:0]      hold_addr_q, hold_wdata_q;
  logic [3:0]       ovr_mask_q, fwd_mask;
  logic [31:0]      ovr_data_q, fwd_data;
  logic             rd_live_q;
  logic             st_vld, full, enq, drain;
  sb_cmd_e          cmd;

  assign st_vld = |st_en;
  assign full   = (count_q == FULL_CNT);
  assign enq    = st_vld & ~full;
  assign stall  = st_vld & full;
  assign empty  = (count_q == '0);

  always_comb begin
    cmd = SB_CMD_IDLE;
    if (ld_req)
      cmd = SB_CMD_READ;
    else if (!empty)
      cmd = SB_CMD_DRAIN;
  end

  assign drain = (cmd == SB_CMD_DRAIN);

  // Idle cycles replay the last address/data so the SRAM pins stay quiet
  always_comb begin
    sram_addr  = hold_addr_q;
    sram_wdata = hold_wdata_q;
    sram_w_en  = SB_WEN_READ;
    case (cmd)
      SB_CMD_READ: sram_addr = addr & 32'hFFFF_FFFC;
      SB_CMD_DRAIN: begin
        sram_addr  = {ent_q[head_q].tag, 2'b00};
        sram_w_en  = ent_q[head_q].mask;
        sram_wdata = ent_q[head_q].data;
      end
      default: ;
    endcase
  end

  always_comb begin
    vld_n = vld_q;
    if (drain)
      vld_n[head_q] = 1'b0;
    if (enq)
      vld_n[tail_q] = 1'b1;
  end

  always_comb begin
    count_n = count_q;
    case ({enq, drain})
      2'b10:   count_n = count_q + (PTR_W+1)'(1);
      2'b01:   count_n = count_q - (PTR_W+1)'(1);
      default: count_n = count_q;
    endcase
  end

  sb_fwd_merge #(.DEPTH(DEPTH)) u_fwd (
    .ents     (ent_q),
    .vld      (vld_q),
    .head     (head_q),
    .tag      (addr[31:2]),
    .fwd_mask (fwd_mask),
    .fwd_data (fwd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      ovr_mask_q   <= '0;
      ovr_data_q   <= '0;
      rd_live_q    <= 1'b0;
    end else begin
      vld_q        <= vld_n;
      count_q      <= count_n;
      hold_addr_q  <= sram_addr;
      hold_wdata_q <= sram_wdata;
      if (enq)
        tail_q <= tail_q + PTR_W'(1);
      if (drain)
        head_q <= head_q + PTR_W'(1);
      if (ld_req) begin
        ovr_mask_q <= fwd_mask;
        ovr_data_q <= fwd_data;
        rd_live_q  <= 1'b1;
      end
    end
  end

  // Payload needs no reset: the valid bits gate every use of it
  always_ff @(posedge clk) begin
    if (enq)
      ent_q[tail_q] <= '{tag: addr[31:2], mask: st_en, data: wdata};
  end

  // ld_data is held at zero from reset until the first load has been issued
  always_comb begin
    ld_data = '0;
    if (rd_live_q) begin
      for (int b = 0; b < 4; b++)
        ld_data[8*b +: 8] = ovr_mask_q[b] ? ovr_data_q[8*b +: 8] : sram_rdata[8*b +: 8];
    end
  end

endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Posted-write buffer between the core's M stage and the synchronous single-port data SRAM.
- It accepts stores from the core without waiting for the SRAM, then drains them to the SRAM in order, FIFO style, whenever the port is idle.
- Loads take priority on the SRAM port. Load data returned to the core is byte-merged with any younger buffered store data to the same word, so the core always sees program-order memory.

Parameters:
DEPTH, 4, number of buffered store entries (power of two, >=2)
PTR_W, $clog2(DEPTH), FIFO pointer width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
st_en  in  4  byte write mask from M stage; nonzero means a store this cycle
ld_req  in  1  M-stage load this cycle
addr  in  32  M-stage byte address; addr[31:2] is the word tag
wdata  in  32  store data, already lane-aligned to st_en
ld_data  out  32  merged load word, valid the cycle after ld_req
stall  out  1  store not accepted this cycle; core holds M stage
empty  out  1  no buffered entries
sram_addr  out  32  SRAM word address (byte address with [1:0]=0)
sram_w_en  out  4  SRAM byte write enables; 0 means read
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data, one cycle after the read address

Behaviour:
- Reset, rst=0 at a clock edge:
  - count=0; head and tail pointers=0; all entries invalid.
  - Merge-capture registers cleared.
  - stall=0, empty=1, sram_w_en=0, sram_addr=0, sram_wdata=0, ld_data=0.
  - Reset mid-operation discards all pending stores. There is no drain.
- Entry fields: word tag[29:0], byte mask[3:0], data[31:0].
- Enqueue:
  - Occurs when st_en!=0 and count<DEPTH.
  - The entry is written at tail on the clock edge; tail and count increment.
  - There is no coalescing, even when the tag matches an existing entry.
- stall:
  - Combinational: stall = (st_en!=0) & (count==DEPTH).
  - While stalled the store is not enqueued. A drain occurs that same cycle, so the stall lasts exactly 1 cycle.
- SRAM port arbitration, one access per cycle:
  - ld_req=1: sram_addr={addr[31:2],2'b00}, sram_w_en=0, no drain.
  - else if count>0: drain the head entry. sram_addr={tag,2'b00}, sram_w_en=mask, sram_wdata=data. Head increments; count decrements.
  - else: sram_w_en=0. sram_addr and sram_wdata hold their previous values.
- Simultaneous enqueue and drain (count<DEPTH): count is unchanged and both pointers advance.
- ld_req together with st_en!=0 is illegal (single M stage). The design treats it as a load and also enqueues the store. The load does not observe the new store.
- Load forwarding, latency 1:
  - On the ld_req cycle, compare addr[31:2] against every valid entry's tag.
  - For each byte lane, take the data from the youngest matching entry whose mask bit is set. Register an 8-bit-per-lane override value and a 4-bit override mask.
  - Next cycle: ld_data lane = override mask ? override byte : sram_rdata lane.
- Between loads, ld_data follows sram_rdata merged with the last captured mask. The core samples it only in the cycle after ld_req.
- Pointer wrap: head and tail wrap modulo DEPTH. full/empty are derived from count (PTR_W+1 bits), never from pointer equality alone.
- empty = (count==0) is registered-state derived and is used by fence and halt logic.

Decomposition:
- Shared package: the entry struct (tag, mask, data), DEPTH default, and the store-buffer SRAM command encoding constants.
- One natural sub-module, sb_fwd_merge: combinational youngest-match byte select over the entry array, given the head pointer and valid bits. It returns the override bytes and mask; the parent registers them.

Test Plan:
- Reset: hold rst=0 for 2 cycles after traffic -> count=0, empty=1, stall=0, sram_w_en=0, ld_data=0.
- Single store: st_en=4'hF, addr=0x100, wdata=0xDEADBEEF, idle next -> cycle+1 drain shows sram_addr=0x100, sram_w_en=F, sram_wdata=0xDEADBEEF; then empty=1.
- Fill and stall (DEPTH=4): 5 back-to-back word stores to 0x0,0x4,0x8,0xC,0x10 with no loads -> no stall on the first 4 (a drain frees a slot each cycle). Then hold ld_req for 4 cycles and issue 4 stores -> count=4. The 5th store sees stall=1 for exactly 1 cycle and is accepted on the next cycle.
- Forwarding merge: SRAM[0x200]=0x11223344; buffered store st_en=4'b0010 data=0x0000AA00; younger store st_en=4'b0011 data=0x0000BBCC; ld_req addr=0x200 -> next-cycle ld_data=0x1122BBCC.
- Load priority: 2 buffered stores plus ld_req for 3 consecutive cycles -> sram_w_en=0 for those 3 cycles, count stays 2, draining resumes the cycle ld_req drops.
- Wrap-around: 10 stores interleaved with drains to distinct addresses -> SRAM receives all 10 in issue order with correct data; head and tail wrap twice; final empty=1.
